// File: rtl/pad_cfg_regs.sv
// APB register block for the pad frame: shadow/active pad configuration with an
// atomic commit, a sticky lock, and a one-shot sampled bootsel strap.
module pad_cfg_regs #(
  parameter int unsigned N_PADS             = 48,
  parameter logic [5:0]  CFG_RST            = 6'h00,
  parameter int unsigned BOOT_SAMPLE_CYCLES = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   apb_psel_i,
  input  logic                   apb_penable_i,
  input  logic                   apb_pwrite_i,
  input  logic [11:0]            apb_paddr_i,
  input  logic [31:0]            apb_pwdata_i,
  output logic [31:0]            apb_prdata_o,
  output logic                   apb_pready_o,
  output logic                   apb_pslverr_o,
  output logic [N_PADS-1:0][5:0] pad_cfg_o,
  output logic                   cfg_update_o,
  input  logic                   bootsel_i,
  output logic                   bootsel_o,
  output logic                   bootsel_valid_o
);

  localparam int unsigned N_CFG_WORDS = 12;
  localparam logic [9:0]  CTRL_IDX    = 10'd12;
  localparam logic [9:0]  STATUS_IDX  = 10'd13;
  localparam logic [7:0]  BOOT_LAST   = 8'(BOOT_SAMPLE_CYCLES - 1);

  logic                          access;
  logic [9:0]                    word_idx;
  logic                          is_cfg;
  logic                          is_ctrl;
  logic                          is_status;
  logic                          addr_err;
  logic                          wr_err;
  logic                          cfg_wr;
  logic                          ctrl_wr;
  logic                          commit_req;
  logic [N_PADS-1:0][5:0]        shadow_reg;
  logic [N_PADS-1:0][5:0]        shadow_next;
  logic [N_PADS-1:0][5:0]        active_reg;
  logic                          pending_reg;
  logic                          lock_reg;
  logic                          cfg_update_reg;
  logic                          sync_meta_reg;
  logic                          sync_reg;
  logic                          bootsel_reg;
  logic                          bootsel_valid_reg;
  logic [7:0]                    boot_cnt_reg;
  logic [N_CFG_WORDS-1:0][31:0]  cfg_rd_word;
  logic [31:0]                   rd_data;
  logic                          unused_bits;

  // Address decode and access qualification
  assign access    = apb_psel_i & apb_penable_i;
  assign word_idx  = apb_paddr_i[11:2];
  assign is_cfg    = word_idx < 10'(N_CFG_WORDS);
  assign is_ctrl   = word_idx == CTRL_IDX;
  assign is_status = word_idx == STATUS_IDX;
  assign addr_err  = ~(is_cfg | is_ctrl | is_status);
  assign wr_err    = apb_pwrite_i & (is_status | (lock_reg & (is_cfg | is_ctrl)));

  assign cfg_wr     = access & apb_pwrite_i & is_cfg & ~lock_reg;
  assign ctrl_wr    = access & apb_pwrite_i & is_ctrl & ~lock_reg;
  assign commit_req = ctrl_wr & apb_pwdata_i[0];

  // Byte lanes of a CFG word beyond the last pad read as zero
  genvar gi, gj;
  generate
    for (gi = 0; gi < N_CFG_WORDS; gi++) begin : g_word
      for (gj = 0; gj < 4; gj++) begin : g_lane
        if (4 * gi + gj < N_PADS) begin : g_pad
          assign cfg_rd_word[gi][8*gj +: 8] = {2'b00, shadow_reg[4*gi+gj]};
        end else begin : g_nopad
          assign cfg_rd_word[gi][8*gj +: 8] = 8'h00;
        end
      end
    end
  endgenerate

  always_comb begin
    shadow_next = shadow_reg;
    for (int unsigned p = 0; p < N_PADS; p++) begin
      if (cfg_wr && word_idx == 10'(p / 4)) begin
        shadow_next[p] = apb_pwdata_i[8*(p%4) +: 6];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned w = 0; w < N_CFG_WORDS; w++) begin
      if (word_idx == 10'(w)) begin
        rd_data = cfg_rd_word[w];
      end
    end
    if (is_ctrl) begin
      rd_data = {30'd0, lock_reg, 1'b0};
    end
    if (is_status) begin
      rd_data = {28'd0, pending_reg, lock_reg, bootsel_valid_reg, bootsel_reg};
    end
  end

  // A commit requested while one is already pending is absorbed by the copy
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shadow_reg     <= {N_PADS{CFG_RST}};
      active_reg     <= {N_PADS{CFG_RST}};
      pending_reg    <= 1'b0;
      lock_reg       <= 1'b0;
      cfg_update_reg <= 1'b0;
    end else begin
      shadow_reg     <= shadow_next;
      cfg_update_reg <= pending_reg;
      pending_reg    <= commit_req & ~pending_reg;
      if (pending_reg) begin
        active_reg <= shadow_reg;
      end
      if (ctrl_wr && apb_pwdata_i[1]) begin
        lock_reg <= 1'b1;
      end
    end
  end

  // Bootsel strap: two-flop synchroniser, sampled once when the counter expires
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_meta_reg     <= 1'b0;
      sync_reg          <= 1'b0;
      bootsel_reg       <= 1'b0;
      bootsel_valid_reg <= 1'b0;
      boot_cnt_reg      <= 8'd0;
    end else begin
      sync_meta_reg <= bootsel_i;
      sync_reg      <= sync_meta_reg;
      if (!bootsel_valid_reg) begin
        boot_cnt_reg <= boot_cnt_reg + 8'd1;
        if (boot_cnt_reg == BOOT_LAST) begin
          bootsel_reg       <= sync_reg;
          bootsel_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign apb_prdata_o    = (access & ~apb_pwrite_i & ~addr_err) ? rd_data : 32'd0;
  assign apb_pslverr_o   = access & (addr_err | wr_err);
  assign apb_pready_o    = 1'b1;
  assign pad_cfg_o       = active_reg;
  assign cfg_update_o    = cfg_update_reg;
  assign bootsel_o       = bootsel_reg;
  assign bootsel_valid_o = bootsel_valid_reg;

  assign unused_bits = ^{apb_paddr_i[1:0], apb_pwdata_i};

endmodule

// File: tb/tb_pad_cfg_regs.sv
// Self-checking bench for pad_cfg_regs: directed scenarios plus randomized APB
// traffic checked against a per-pad behavioural model.
module tb_pad_cfg_regs;

  localparam int NP  = 48;
  localparam int BSC = 16;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              psel = 1'b0;
  logic              penable = 1'b0;
  logic              pwrite = 1'b0;
  logic [11:0]       paddr = '0;
  logic [31:0]       pwdata = '0;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;
  logic [NP-1:0][5:0] pad_cfg;
  logic              cfg_update;
  logic              bootsel_i = 1'b0;
  logic              bootsel_o;
  logic              bootsel_valid;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int unsigned shadow_m [NP];
  int unsigned active_m [NP];
  bit          lock_m, pend_m, upd_m, boot_m, valid_m;
  int          k_m;
  bit          hist_m [256];

  pad_cfg_regs #(
    .N_PADS(NP),
    .CFG_RST(6'h00),
    .BOOT_SAMPLE_CYCLES(BSC)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .apb_psel_i(psel),
    .apb_penable_i(penable),
    .apb_pwrite_i(pwrite),
    .apb_paddr_i(paddr),
    .apb_pwdata_i(pwdata),
    .apb_prdata_o(prdata),
    .apb_pready_o(pready),
    .apb_pslverr_o(pslverr),
    .pad_cfg_o(pad_cfg),
    .cfg_update_o(cfg_update),
    .bootsel_i(bootsel_i),
    .bootsel_o(bootsel_o),
    .bootsel_valid_o(bootsel_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rdata(input bit w, input logic [11:0] a);
    int unsigned idx = 32'(a[11:2]);
    int unsigned v = 0;
    if (w) return 32'd0;
    if (idx < 12) begin
      for (int j = 0; j < 4; j++)
        if (4 * idx + j < NP) v += shadow_m[4*idx+j] << (8 * j);
    end else if (idx == 12) begin
      v = 32'(lock_m) * 2;
    end else if (idx == 13) begin
      v = 32'(boot_m) + 32'(valid_m) * 2 + 32'(lock_m) * 4 + 32'(pend_m) * 8;
    end
    return v;
  endfunction

  function automatic bit exp_err(input bit w, input logic [11:0] a);
    int unsigned idx = 32'(a[11:2]);
    if (idx > 13) return 1'b1;
    if (w && idx == 13) return 1'b1;
    if (w && lock_m) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [287:0] active_vec();
    logic [287:0] v = '0;
    for (int p = 0; p < NP; p++) v[6*p +: 6] = 6'(active_m[p]);
    return v;
  endfunction

  // One rising edge of the model, using the inputs currently driven
  task automatic model_edge();
    bit          pend0 = pend_m;
    int unsigned idx = 32'(paddr[11:2]);
    if (!rst_ni) begin
      for (int p = 0; p < NP; p++) begin
        shadow_m[p] = 0;
        active_m[p] = 0;
      end
      lock_m = 0; pend_m = 0; upd_m = 0; boot_m = 0; valid_m = 0; k_m = 0;
      return;
    end
    upd_m = pend0;
    if (pend0) for (int p = 0; p < NP; p++) active_m[p] = shadow_m[p];
    pend_m = 0;
    if (psel && penable && pwrite && !lock_m) begin
      if (idx < 12) begin
        for (int j = 0; j < 4; j++)
          if (4 * idx + j < NP) shadow_m[4*idx+j] = (pwdata >> (8 * j)) & 32'h3F;
      end else if (idx == 12) begin
        if (pwdata[0] && !pend0) pend_m = 1;
        if (pwdata[1]) lock_m = 1;
      end
    end
    if (!valid_m) begin
      k_m++;
      hist_m[k_m] = bootsel_i;
      if (k_m == BSC) begin
        boot_m  = (BSC >= 3) ? hist_m[BSC-2] : 1'b0;
        valid_m = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("pad_cfg", pad_cfg, active_vec());
    check("cfg_update", cfg_update, upd_m);
    check("bootsel_o", bootsel_o, boot_m);
    check("bootsel_valid", bootsel_valid, valid_m);
  endtask

  // Single-cycle access (psel and penable together); called at a falling edge
  task automatic apb(input bit w, input logic [11:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    psel = 1'b1; penable = 1'b1; pwrite = w; paddr = a; pwdata = d;
    #1;
    rd  = prdata;
    err = pslverr;
    check("prdata", rd, exp_rdata(w, a));
    check("pslverr", err, exp_err(w, a));
    check("pready", pready, 1'b1);
    step();
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [9:0]  idx;
    logic [1:0]  lo;
    logic [31:0] d;
    bit          w;

    // Reset and bootsel = 1 strap
    bootsel_i = 1'b1;
    rst_ni = 1'b0;
    repeat (3) step();
    check("rst_pad_cfg", pad_cfg, 288'd0);
    rst_ni = 1'b1;
    apb(0, 12'h000, 32'd0, rd, err);
    check("rst_cfg0", rd, 32'h0);
    apb(0, 12'h034, 32'd0, rd, err);
    check("rst_status", rd, 32'h0);
    repeat (BSC - 3) step();
    check("valid_before", bootsel_valid, 1'b0);
    step();
    check("valid_at", bootsel_valid, 1'b1);
    check("boot_one", bootsel_o, 1'b1);
    repeat (6) begin
      bootsel_i = ~bootsel_i;
      step();
    end
    apb(0, 12'h034, 32'd0, rd, err);
    check("status_boot", rd[1:0], 2'b11);

    // Shadow write, readback, commit
    apb(1, 12'h014, 32'hFF3F0201, rd, err);
    check("cfg5_no_active", pad_cfg[23:20], 24'd0);
    apb(0, 12'h014, 32'd0, rd, err);
    check("cfg5_readback", rd, 32'h3F3F0201);
    apb(1, 12'h030, 32'h1, rd, err);
    check("commit_wait", cfg_update, 1'b0);
    step();
    check("pad20", pad_cfg[20], 6'h01);
    check("pad21", pad_cfg[21], 6'h02);
    check("pad22", pad_cfg[22], 6'h3F);
    check("pad23", pad_cfg[23], 6'h3F);
    check("upd_pulse", cfg_update, 1'b1);
    step();
    check("upd_end", cfg_update, 1'b0);

    // Shadow write landing in the copy cycle misses that commit
    apb(1, 12'h030, 32'h1, rd, err);
    apb(1, 12'h000, 32'h1, rd, err);
    check("race_pad0", pad_cfg[0], 6'h00);
    step();
    check("race_pad0_hold", pad_cfg[0], 6'h00);
    apb(1, 12'h030, 32'h1, rd, err);
    step();
    check("recommit_pad0", pad_cfg[0], 6'h01);

    // Unmapped addresses and STATUS write
    apb(0, 12'h038, 32'd0, rd, err);
    check("idx14_rd_err", err, 1'b1);
    check("idx14_rd_data", rd, 32'd0);
    apb(1, 12'h038, 32'h12345678, rd, err);
    check("idx14_wr_err", err, 1'b1);
    apb(0, 12'hFFC, 32'd0, rd, err);
    check("idx3ff_rd_err", err, 1'b1);
    check("idx3ff_rd_data", rd, 32'd0);
    apb(1, 12'hFFC, 32'hFFFFFFFF, rd, err);
    check("idx3ff_wr_err", err, 1'b1);
    apb(1, 12'h034, 32'hF, rd, err);
    check("status_wr_err", err, 1'b1);

    // Randomized traffic (lock never set here), bootsel toggling after sampling
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11: idx = 10'($urandom_range(0, 11));
        12, 13:  idx = 10'd12;
        14:      idx = 10'd13;
        15:      idx = 10'd14;
        16:      idx = 10'h3FF;
        default: idx = 10'($urandom_range(0, 1023));
      endcase
      lo = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      d  = $urandom;
      if (idx == 10'd12) d = {31'd0, d[0]};
      bootsel_i = 1'($urandom_range(0, 1));
      apb(w, {idx, lo}, d, rd, err);
      if ($urandom_range(0, 3) == 0) step();
    end

    // Bootsel = 0 strap
    bootsel_i = 1'b0;
    rst_ni = 1'b0;
    repeat (2) step();
    rst_ni = 1'b1;
    repeat (BSC - 1) step();
    check("valid0_before", bootsel_valid, 1'b0);
    step();
    check("valid0_at", bootsel_valid, 1'b1);
    check("boot_zero", bootsel_o, 1'b0);
    repeat (6) begin
      bootsel_i = ~bootsel_i;
      step();
    end
    check("boot_zero_hold", bootsel_o, 1'b0);

    // Commit together with lock, then locked behaviour
    apb(1, 12'h004, 32'h00000505, rd, err);
    apb(1, 12'h030, 32'h3, rd, err);
    step();
    check("lock_commit_pad4", pad_cfg[4], 6'h05);
    check("lock_commit_pad5", pad_cfg[5], 6'h05);
    apb(1, 12'h004, 32'h3, rd, err);
    check("locked_cfg_err", err, 1'b1);
    apb(0, 12'h004, 32'd0, rd, err);
    check("locked_readback", rd, 32'h00000505);
    apb(1, 12'h030, 32'h0, rd, err);
    check("locked_ctrl_err", err, 1'b1);
    apb(0, 12'h034, 32'd0, rd, err);
    check("lock_sticky", rd[2], 1'b1);
    apb(1, 12'h030, 32'h1, rd, err);
    step();
    check("locked_no_upd", cfg_update, 1'b0);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    apb(0, 12'h034, 32'd0, rd, err);
    check("lock_cleared", rd[2], 1'b0);

    // Reset while a commit is pending
    apb(1, 12'h008, 32'h0000002A, rd, err);
    apb(1, 12'h030, 32'h1, rd, err);
    rst_ni = 1'b0;
    step();
    check("rst_pend_upd", cfg_update, 1'b0);
    check("rst_pend_pads", pad_cfg, 288'd0);
    step();
    check("rst_pend_upd2", cfg_update, 1'b0);
    rst_ni = 1'b1;
    step();
    apb(0, 12'h008, 32'd0, rd, err);
    check("rst_pend_shadow", rd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
